// File: rtl/apb_pkg.sv
// Shared definitions for the APB master: FSM state encoding and the GPIO
// peripheral register map it usually talks to.
package apb_pkg;

  typedef logic [1:0] apb_state_t;

  localparam apb_state_t ST_IDLE   = 2'd0;
  localparam apb_state_t ST_SETUP  = 2'd1;
  localparam apb_state_t ST_ACCESS = 2'd2;

  // GPIO slave register addresses
  localparam logic [3:0] GPIO_MODE      = 4'd0;
  localparam logic [3:0] GPIO_DIRECTION = 4'd1;
  localparam logic [3:0] GPIO_OUTPUT    = 4'd2;
  localparam logic [3:0] GPIO_INPUT     = 4'd3;

endpackage

// File: rtl/apb_master_timeout.sv
// ACCESS-phase watchdog: counts cycles while enabled and flags the last
// allowed cycle. Only built when APB_MASTER_TIMEOUT_EN is defined.
module apb_master_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned    CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  W_LAST  = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + CW'(1);
    end
  end

  // High during the final ACCESS cycle the master is willing to wait.
  assign o_expired = i_enable && (r_count == W_LAST);

endmodule

// File: rtl/apb_master.sv
// Single-command APB master: IDLE -> SETUP -> ACCESS per transfer.
// Optional ACCESS timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned PDATA_SIZE = 32,
  parameter int unsigned PADDR_SIZE = 4
`ifdef APB_MASTER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [PADDR_SIZE-1:0]     cmd_addr,
  input  logic [PDATA_SIZE-1:0]     cmd_wdata,
  input  logic [PDATA_SIZE/8-1:0]   cmd_strb,
  output logic                      rsp_valid,
  output logic [PDATA_SIZE-1:0]     rsp_rdata,
  output logic                      rsp_err,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [PADDR_SIZE-1:0]     PADDR,
  output logic [PDATA_SIZE-1:0]     PWDATA,
  output logic [PDATA_SIZE/8-1:0]   PSTRB,
  input  logic [PDATA_SIZE-1:0]     PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  apb_state_t                r_state;
  logic                      r_psel;
  logic                      r_penable;
  logic                      r_pwrite;
  logic [PADDR_SIZE-1:0]     r_paddr;
  logic [PDATA_SIZE-1:0]     r_pwdata;
  logic [PDATA_SIZE/8-1:0]   r_pstrb;
  logic                      r_rsp_valid;
  logic [PDATA_SIZE-1:0]     r_rsp_rdata;
  logic                      r_rsp_err;
  logic                      w_accept;
  logic                      w_timeout;

  assign cmd_ready = (r_state == ST_IDLE);
  assign w_accept  = cmd_valid && cmd_ready;

`ifdef APB_MASTER_TIMEOUT_EN
  apb_master_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (PCLK),
    .i_rst     (PRESET),
    .i_clear   (r_state == ST_SETUP),
    .i_enable  (r_state == ST_ACCESS),
    .o_expired (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values and the block order does not matter.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state     <= ST_IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      // Response flags are single-cycle pulses unless completion re-raises them.
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state  <= ST_SETUP;
            r_psel   <= 1'b1;
            r_pwrite <= cmd_write;
            r_paddr  <= cmd_addr;
            r_pwdata <= cmd_write ? cmd_wdata : '0;
            r_pstrb  <= cmd_write ? cmd_strb  : '0;
          end
        end
        ST_SETUP: begin
          r_state   <= ST_ACCESS;
          r_penable <= 1'b1;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            r_state     <= ST_IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= PSLVERR;
            if (!r_pwrite) r_rsp_rdata <= PRDATA;
          end else if (w_timeout) begin
            r_state     <= ST_IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
        end
      endcase
    end
  end

  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign PSTRB     = r_pstrb;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed scenarios plus randomized transfers checked
// against a transaction-level model of the expected APB and response behaviour.
module tb_apb_master;
  import apb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int SW = 4;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_strb;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [SW-1:0] PSTRB;
  logic [DW-1:0] PRDATA;
  logic          PREADY, PSLVERR;

  apb_master dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad   = 0;

  // Reference: rsp_rdata holds the data of the last completed read (0 after reset).
  logic [DW-1:0] model_rdata;

  // Observations collected by run_xfer
  logic          o_ready_acc, o_s_psel, o_s_pen, o_s_pwrite;
  logic [AW-1:0] o_s_paddr;
  logic [DW-1:0] o_s_pwdata;
  logic [SW-1:0] o_s_pstrb;
  logic          o_a_psel, o_a_pen, o_stable, o_early;
  logic          o_rsp_valid, o_rsp_err, o_end_psel, o_end_pen, o_end_ready;
  logic [DW-1:0] o_rsp_rdata;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Drives one command and plays the slave: nwait ACCESS cycles with PREADY
  // low, then PREADY high with rd/err. Returns at the rsp_valid cycle.
  task automatic run_xfer(input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s,
                          input int nwait, input logic [DW-1:0] rd,
                          input logic err, input logic hold);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
    PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
    o_ready_acc = cmd_ready;
    o_early = 1'b0;
    tick();
    if (!hold) begin
      cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 4'($urandom);
      cmd_wdata = $urandom; cmd_strb = 4'($urandom);
    end
    o_s_psel = PSEL; o_s_pen = PENABLE; o_s_pwrite = PWRITE;
    o_s_paddr = PADDR; o_s_pwdata = PWDATA; o_s_pstrb = PSTRB;
    o_early |= rsp_valid;
    tick();
    o_a_psel = PSEL; o_a_pen = PENABLE;
    o_early |= rsp_valid;
    o_stable = (PADDR === o_s_paddr) && (PWRITE === o_s_pwrite) &&
               (PWDATA === o_s_pwdata) && (PSTRB === o_s_pstrb);
    for (int i = 0; i < nwait; i++) begin
      PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
      tick();
      if (!(PSEL === 1'b1 && PENABLE === 1'b1 && PADDR === o_s_paddr &&
            PWRITE === o_s_pwrite && PWDATA === o_s_pwdata && PSTRB === o_s_pstrb))
        o_stable = 1'b0;
      o_early |= rsp_valid;
    end
    PREADY = 1'b1; PRDATA = rd; PSLVERR = err;
    tick();
    o_rsp_valid = rsp_valid; o_rsp_err = rsp_err; o_rsp_rdata = rsp_rdata;
    o_end_psel = PSEL; o_end_pen = PENABLE; o_end_ready = cmd_ready;
    PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
  endtask

  task automatic test_reset();
    logic [DW+DW+AW+SW+5:0] all_out;
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_strb = '0; PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    tick(); tick();
    all_out = {PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid, rsp_rdata, rsp_err};
    total++;
    if (all_out !== '0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    PRESET = 1'b0;
    tick();
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
    end
    model_rdata = '0;
  endtask

  task automatic test_write_basic();
    run_xfer(1'b1, GPIO_DIRECTION, 32'h0000_00FF, 4'hF, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    total++;
    if ({o_ready_acc, o_s_psel, o_s_pen, o_s_pwrite} !== 4'b1101) begin
      bad++; $display("FAIL wr_setup_ctrl: got %b want 1101", {o_ready_acc, o_s_psel, o_s_pen, o_s_pwrite});
    end
    total++;
    if ({o_s_paddr, o_s_pwdata, o_s_pstrb} !== {GPIO_DIRECTION, 32'h0000_00FF, 4'hF}) begin
      bad++; $display("FAIL wr_setup_data: got %h/%h/%h want 1/000000ff/f", o_s_paddr, o_s_pwdata, o_s_pstrb);
    end
    total++;
    if ({o_a_psel, o_a_pen, o_early} !== 3'b110) begin
      bad++; $display("FAIL wr_access: got %b want 110", {o_a_psel, o_a_pen, o_early});
    end
    total++;
    if ({o_rsp_valid, o_rsp_err, o_end_psel, o_end_pen, o_end_ready} !== 5'b10001) begin
      bad++; $display("FAIL wr_rsp_cycle3: got %b want 10001", {o_rsp_valid, o_rsp_err, o_end_psel, o_end_pen, o_end_ready});
    end
    total++;
    if (o_rsp_rdata !== model_rdata) begin
      bad++; $display("FAIL wr_rdata_hold: got %h want %h", o_rsp_rdata, model_rdata);
    end
    tick();
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL wr_rsp_pulse: got %b want 0", rsp_valid);
    end
  endtask

  task automatic test_read_wait();
    run_xfer(1'b0, GPIO_INPUT, 32'h1234_5678, 4'hF, 3, 32'hA5A5_5A5A, 1'b0, 1'b0);
    model_rdata = 32'hA5A5_5A5A;
    total++;
    if ({o_s_paddr, o_s_pwrite, o_s_pstrb, o_s_pwdata} !== {GPIO_INPUT, 1'b0, 4'h0, 32'h0}) begin
      bad++; $display("FAIL rd_setup: got %h/%b/%h/%h want 3/0/0/0", o_s_paddr, o_s_pwrite, o_s_pstrb, o_s_pwdata);
    end
    total++;
    if ({o_stable, o_a_pen, o_early} !== 3'b110) begin
      bad++; $display("FAIL rd_wait_stable: got %b want 110", {o_stable, o_a_pen, o_early});
    end
    total++;
    if ({o_rsp_valid, o_rsp_err, o_rsp_rdata} !== {2'b10, 32'hA5A5_5A5A}) begin
      bad++; $display("FAIL rd_rsp: got %b/%b/%h want 1/0/a5a55a5a", o_rsp_valid, o_rsp_err, o_rsp_rdata);
    end
    tick();
  endtask

  task automatic test_slverr();
    run_xfer(1'b1, GPIO_OUTPUT, 32'hCAFE_0001, 4'h3, 1, 32'h0, 1'b1, 1'b0);
    total++;
    if ({o_rsp_valid, o_rsp_err, o_rsp_rdata} !== {2'b11, model_rdata}) begin
      bad++; $display("FAIL err_rsp: got %b/%b/%h want 1/1/%h", o_rsp_valid, o_rsp_err, o_rsp_rdata, model_rdata);
    end
    tick();
    total++;
    if ({rsp_valid, rsp_err, cmd_ready} !== 3'b001) begin
      bad++; $display("FAIL err_pulse: got %b want 001", {rsp_valid, rsp_err, cmd_ready});
    end
    run_xfer(1'b0, GPIO_MODE, 32'h0, 4'hF, 0, 32'h0BAD_F00D, 1'b0, 1'b0);
    model_rdata = 32'h0BAD_F00D;
    total++;
    if ({o_ready_acc, o_s_psel, o_rsp_valid, o_rsp_err, o_rsp_rdata} !== {4'b1110, 32'h0BAD_F00D}) begin
      bad++; $display("FAIL err_next_cmd: got %b%b%b%b/%h want 1110/0badf00d", o_ready_acc, o_s_psel, o_rsp_valid, o_rsp_err, o_rsp_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    run_xfer(1'b1, GPIO_OUTPUT, 32'h5555_AAAA, 4'hC, 2, 32'h0, 1'b0, 1'b1);
    total++;
    if ({o_s_psel, o_s_pen, o_a_pen, o_stable, o_early, o_rsp_valid, o_end_psel, o_end_ready} !== 8'b10110101) begin
      bad++; $display("FAIL held_first: got %b want 10110101", {o_s_psel, o_s_pen, o_a_pen, o_stable, o_early, o_rsp_valid, o_end_psel, o_end_ready});
    end
    tick();
    cmd_valid = 1'b0;
    total++;
    if ({PSEL, PENABLE, rsp_valid, PADDR, PWDATA} !== {3'b100, GPIO_OUTPUT, 32'h5555_AAAA}) begin
      bad++; $display("FAIL held_second_setup: got %b%b%b/%h/%h want 100/2/5555aaaa", PSEL, PENABLE, rsp_valid, PADDR, PWDATA);
    end
    tick();
    PREADY = 1'b1; PRDATA = $urandom; PSLVERR = 1'b0;
    tick();
    PREADY = 1'b0;
    total++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, model_rdata}) begin
      bad++; $display("FAIL held_second_rsp: got %b/%b/%h want 1/0/%h", rsp_valid, rsp_err, rsp_rdata, model_rdata);
    end
    tick();
  endtask

`ifdef APB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    logic early_done;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = GPIO_INPUT; cmd_strb = '0;
    PREADY = 1'b0; PRDATA = 32'hFFFF_0000;
    tick();
    cmd_valid = 1'b0;
    tick();
    early_done = 1'b0;
    for (int i = 1; i < 16; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || PENABLE !== 1'b1) early_done = 1'b1;
    end
    total++;
    if (early_done !== 1'b0) begin
      bad++; $display("FAIL to_early: got %b want 0", early_done);
    end
    tick();
    model_rdata = '0;
    total++;
    if ({rsp_valid, rsp_err, PSEL, PENABLE, rsp_rdata} !== {4'b1100, 32'h0}) begin
      bad++; $display("FAIL to_expire: got %b%b%b%b/%h want 1100/0", rsp_valid, rsp_err, PSEL, PENABLE, rsp_rdata);
    end
    tick();
  endtask
`else
  task automatic test_no_timeout();
    run_xfer(1'b0, GPIO_INPUT, 32'h0, 4'h0, 40, 32'h7777_1111, 1'b0, 1'b0);
    model_rdata = 32'h7777_1111;
    total++;
    if ({o_stable, o_early, o_rsp_valid, o_rsp_err, o_rsp_rdata} !== {4'b1010, 32'h7777_1111}) begin
      bad++; $display("FAIL long_wait: got %b%b%b%b/%h want 1010/77771111", o_stable, o_early, o_rsp_valid, o_rsp_err, o_rsp_rdata);
    end
    tick();
  endtask
`endif

  task automatic test_random();
    logic          w, err;
    logic [AW-1:0] a;
    logic [DW-1:0] d, rd, exp_rdata;
    logic [SW-1:0] s;
    int            nwait, idle;
    for (int n = 0; n < 40; n++) begin
      w = 1'($urandom); a = 4'($urandom); d = $urandom; s = 4'($urandom);
      rd = $urandom; err = 1'($urandom); nwait = int'($urandom_range(0, 4));
      run_xfer(w, a, d, s, nwait, rd, err, 1'b0);
      exp_rdata = w ? model_rdata : rd;
      model_rdata = exp_rdata;
      total++;
      if ({o_ready_acc, o_s_psel, o_s_pen, o_a_psel, o_a_pen, o_stable, o_early} !== 7'b1101110) begin
        bad++; $display("FAIL rnd_phases[%0d]: got %b want 1101110", n, {o_ready_acc, o_s_psel, o_s_pen, o_a_psel, o_a_pen, o_stable, o_early});
      end
      total++;
      if ({o_s_pwrite, o_s_paddr, o_s_pwdata, o_s_pstrb} !== {w, a, (w ? d : 32'h0), (w ? s : 4'h0)}) begin
        bad++; $display("FAIL rnd_setup[%0d]: got %b/%h/%h/%h want %b/%h/%h/%h", n, o_s_pwrite, o_s_paddr, o_s_pwdata, o_s_pstrb, w, a, (w ? d : 32'h0), (w ? s : 4'h0));
      end
      total++;
      if ({o_rsp_valid, o_rsp_err, o_end_psel, o_end_pen, o_end_ready, o_rsp_rdata} !== {1'b1, err, 3'b001, exp_rdata}) begin
        bad++; $display("FAIL rnd_rsp[%0d]: got %b%b%b%b%b/%h want 1%b001/%h", n, o_rsp_valid, o_rsp_err, o_end_psel, o_end_pen, o_end_ready, o_rsp_rdata, err, exp_rdata);
      end
      idle = int'($urandom_range(0, 2));
      for (int k = 0; k < idle; k++) begin
        tick();
        total++;
        if ({rsp_valid, rsp_err, PSEL, cmd_ready} !== 4'b0001) begin
          bad++; $display("FAIL rnd_idle[%0d]: got %b want 0001", n, {rsp_valid, rsp_err, PSEL, cmd_ready});
        end
      end
    end
    tick();
  endtask

  task automatic test_reset_in_access();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = GPIO_MODE;
    PREADY = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    total++;
    if ({PSEL, PENABLE} !== 2'b11) begin
      bad++; $display("FAIL rst_acc_enter: got %b want 11", {PSEL, PENABLE});
    end
    PRESET = 1'b1; PREADY = 1'b1; PRDATA = 32'h1357_9BDF; PSLVERR = 1'b1;
    tick();
    PRESET = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
    model_rdata = '0;
    total++;
    if ({PSEL, PENABLE, rsp_valid, rsp_err, cmd_ready, rsp_rdata} !== {5'b00001, 32'h0}) begin
      bad++; $display("FAIL rst_acc_abort: got %b%b%b%b%b/%h want 00001/0", PSEL, PENABLE, rsp_valid, rsp_err, cmd_ready, rsp_rdata);
    end
    tick();
    total++;
    if ({PSEL, rsp_valid, cmd_ready} !== 3'b001) begin
      bad++; $display("FAIL rst_acc_after: got %b want 001", {PSEL, rsp_valid, cmd_ready});
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_wait();
    test_slverr();
    test_back_to_back();
`ifdef APB_MASTER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    test_reset_in_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
